// File: rtl/block_data_memory_if.sv
// Memory-side block transfer handshake between the data cache (master) and
// the block data memory (slave).
interface block_data_memory_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/block_data_memory.sv
// Block-granular main memory behind the data cache: fixed-latency refills
// and write-backs, with busywait held high until the access completes.
module block_data_memory #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 5
) (
  input logic               clock,
  input logic               reset,
  block_data_memory_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      counter;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  accept;
  logic                  complete;
  logic                  busy;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.read || bus.write) begin
          accept     = 1'b1;
          busy       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (counter == '0) begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The cache samples busywait at the next edge, so reset must mask it now.
    if (reset) busy = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter    <= '0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      if (accept) begin
        op_write <= bus.write;
        addr_q   <= bus.address;
        wdata_q  <= bus.writedata;
        counter  <= CNT_W'(LATENCY - 1);
      end else if (state == ACCESS && counter != '0) begin
        counter <= counter - CNT_W'(1);
      end
      if (complete && !op_write) readdata_q <= mem[addr_q];
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // reset only suppresses an in-flight write.
  always_ff @(posedge clock) begin
    if (!reset && complete && op_write) mem[addr_q] <= wdata_q;
  end

  assign bus.readdata = readdata_q;
  assign bus.busywait = busy;
endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level memory model.
module tb_block_data_memory;
  localparam int LAT = 5;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  block_data_memory_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();
  block_data_memory_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus1 ();

  block_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  block_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (bus1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] ref_mem [64];
  logic        ref_valid [64];
  logic [31:0] ref_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_apply(input logic rd, input logic wr, input logic [5:0] a,
                             input logic [31:0] d);
    if (wr) begin
      ref_mem[a]   = d;
      ref_valid[a] = 1'b1;
    end else if (rd) begin
      ref_rd = ref_mem[a];
    end
  endtask

  // Counts busy cycles from the current cycle; returns positioned in DONE.
  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (bus.busywait && n < 50) begin
      n++;
      tick();
      #1;
    end
  endtask

  task automatic transact(input logic rd, input logic wr, input logic [5:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string tag);
    int n;
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = d;
    wait_done(n);
    check({tag, " busy cycles"}, 32'(n), 32'(LAT + 1));
    check({tag, " readdata"}, bus.readdata, exp);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           n;
    logic         pat [10];
    logic         rd, wr;
    logic [5:0]   a;
    logic [31:0]  d;

    vecs[0]  = '{1'b0, 1'b1, 6'h0A, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 6'h0A, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 6'h03, 32'h11111111, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 6'h05, 32'h22222222, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 6'h05, 32'h0,        32'h22222222};
    vecs[5]  = '{1'b1, 1'b1, 6'h03, 32'hCAFEF00D, 32'h22222222};
    vecs[6]  = '{1'b1, 1'b0, 6'h03, 32'h0,        32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 6'h01, 32'h01020304, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b1, 6'h02, 32'hF0F0F0F0, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b1, 6'h07, 32'hAAAAAAAA, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 1'b1, 6'h3F, 32'h12345678, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h12345678};
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]   = '0;
      ref_valid[i] = 1'b0;
    end
    ref_rd = '0;

    // Reset held with a request present: busywait must stay low.
    reset          = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus1.read      = 1'b0;
    bus1.write     = 1'b0;
    bus1.address   = '0;
    bus1.writedata = '0;
    tick();
    tick();
    #1;
    check("reset busywait", 32'(bus.busywait), 32'd0);
    check("reset readdata", bus.readdata, 32'h0);
    check("reset readdata lat1", bus1.readdata, 32'h0);
    bus.read = 1'b0;
    reset    = 1'b0;
    tick();
    #1;
    check("idle busywait", 32'(bus.busywait), 32'd0);

    for (int i = 0; i < 12; i++) begin
      transact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
               $sformatf("vec%0d", i));
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Request held through DONE: one access, then a fresh one in the next IDLE.
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus.read    = 1'b1;
        bus.address = 6'h0A;
      end
      #1;
      check($sformatf("held busywait c%0d", i), 32'(bus.busywait), 32'(pat[i]));
      if (i == 6) check("held readdata done", bus.readdata, 32'hDEADBEEF);
      tick();
    end
    bus.read = 1'b0;
    wait_done(n);
    check("held second access readdata", bus.readdata, 32'hDEADBEEF);
    tick();
    model_apply(1'b1, 1'b0, 6'h0A, 32'h0);

    // Inputs change during ACCESS: the latched address must be used.
    bus.read    = 1'b1;
    bus.address = 6'h01;
    tick();
    bus.address = 6'h02;
    bus.read    = 1'b0;
    wait_done(n);
    check("midaccess remaining busy", 32'(n), 32'(LAT));
    check("midaccess readdata", bus.readdata, 32'h01020304);
    tick();
    model_apply(1'b1, 1'b0, 6'h01, 32'h0);

    // Reset during the 3rd ACCESS cycle of a write aborts it.
    bus.write     = 1'b1;
    bus.address   = 6'h07;
    bus.writedata = 32'h55555555;
    tick();
    tick();
    tick();
    reset     = 1'b1;
    bus.write = 1'b0;
    tick();
    #1;
    check("abort busywait", 32'(bus.busywait), 32'd0);
    check("abort readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    tick();
    ref_rd = '0;
    transact(1'b1, 1'b0, 6'h07, 32'h0, 32'hAAAAAAAA, "abort readback");
    model_apply(1'b1, 1'b0, 6'h07, 32'h0);

    // LATENCY=1 instance: two busy cycles, DONE in the third.
    bus1.write     = 1'b1;
    bus1.address   = 6'h09;
    bus1.writedata = 32'h0BADCAFE;
    n = 0;
    #1;
    while (bus1.busywait && n < 50) begin n++; tick(); #1; end
    check("lat1 write busy", 32'(n), 32'd2);
    bus1.write = 1'b0;
    tick();
    bus1.read = 1'b1;
    n = 0;
    #1;
    while (bus1.busywait && n < 50) begin n++; tick(); #1; end
    check("lat1 read busy", 32'(n), 32'd2);
    check("lat1 readdata", bus1.readdata, 32'h0BADCAFE);
    bus1.read = 1'b0;
    tick();

    // Randomized traffic against the model; reads only hit written blocks.
    for (int i = 0; i < 60; i++) begin
      a  = 6'($urandom_range(0, 63));
      d  = $urandom;
      wr = ($urandom_range(0, 2) == 0) || !ref_valid[a];
      rd = !wr || ($urandom_range(0, 3) == 0);
      model_apply(rd, wr, a, d);
      transact(rd, wr, a, d, ref_rd, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Main data memory directly downstream of the data cache. Services whole-block refills and write-backs over the cache's memory-side handshake.
- Capacity: 64 blocks x 32 bits. Block address = {tag, index} from the cache.
- Fixed multi-cycle access latency, signalled with busywait.

Parameters:
- ADDR_WIDTH, 6, block address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, block width in bits.
- LATENCY, 5, cycles spent in ACCESS per request; legal values are 1 or more.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  block read request; held by the cache until busywait falls.
- write  input  1  block write request; held by the cache until busywait falls.
- address  input  ADDR_WIDTH  block address.
- writedata  input  DATA_WIDTH  block to write.
- readdata  output  DATA_WIDTH  block returned by the last completed read; registered.
- busywait  output  1  high while a request is pending or in progress.

Behaviour:
- Interface (decided): one clock, clock; reset is synchronous and active-high.
- States:
  - IDLE: no operation in progress.
  - ACCESS: latency countdown.
  - DONE: one-cycle completion.
- Reset (sampled at the edge, overrides everything):
  - state goes to IDLE, counter to 0, readdata to 0, latched request cleared.
  - Array contents are NOT modified.
  - busywait is 0 once reset has taken effect; it stays 0 while reset is held, regardless of read/write.
- busywait (combinational):
  - 1 when state==IDLE and (read|write) and not reset.
  - 1 in ACCESS.
  - 0 in DONE and otherwise.
  - It must rise in the same cycle the request appears, because the cache samples it at the next edge.
- IDLE, with read|write at the edge:
  - Latch address, writedata and operation type: write if write=1, else read. Write wins if both are asserted.
  - Load counter with LATENCY-1 and go to ACCESS.
- ACCESS:
  - Inputs are ignored; the latched values are used even if read, write or address change, or the request drops.
  - While counter > 0: decrement.
  - At the edge where counter == 0:
    - Latched write: store latched writedata into mem[latched address].
    - Latched read: load readdata from mem[latched address].
    - Go to DONE.
- DONE:
  - busywait = 0 and readdata is valid for this cycle.
  - Go to IDLE unconditionally at the next edge. A request still asserted in DONE is ignored, so the cache's held request is not re-serviced.
- Latency: a request asserted in cycle c sees busywait high for cycles c..c+LATENCY, and busywait low in cycle c+LATENCY+1 (DONE).
- Back-to-back: the earliest new request can be accepted is in the IDLE cycle after DONE.
- readdata:
  - Changes only on read completion or reset.
  - Holds its value through writes and idle cycles.
- Reset mid-operation (ACCESS or DONE): the operation is aborted. A pending write never reaches the array.
- Write-then-read to the same address returns the new data; there is no forwarding and no hazard.
- Out-of-range addresses are impossible, since depth = 2**ADDR_WIDTH.

Test Plan:
- Write then read, LATENCY=5:
  - write=1, address=6'h0A, writedata=32'hDEADBEEF -> busywait high 6 cycles, low in the 7th.
  - Drop write; read=1, address=6'h0A -> after 6 busy cycles, readdata=32'hDEADBEEF in the DONE cycle.
- Request held through DONE: keep read=1, address=6'h0A for 10 cycles -> exactly one access. busywait pattern is 1x6, 0 (DONE), then 1 again in the following IDLE cycle because read is still high.
- Simultaneous read and write:
  - Preload mem[3]=32'h11111111 and readdata=32'h22222222 (via an earlier read of mem[5]=32'h22222222).
  - Assert read=write=1, address=3, writedata=32'hCAFEF00D -> mem[3]=32'hCAFEF00D and readdata stays 32'h22222222.
- Inputs change mid-access: start a read of address 1 (mem[1]=32'h01020304), then change address to 2 and drop read during ACCESS -> readdata=32'h01020304 at DONE.
- Reset mid-write:
  - mem[7]=32'hAAAAAAAA. Start a write of 32'h55555555 to address 7; assert reset in the 3rd ACCESS cycle.
  - Expect busywait=0 and readdata=0 after the edge.
  - A subsequent read of address 7 returns 32'hAAAAAAAA.
- LATENCY=1 build: a read request is busy for 2 cycles, with DONE in the 3rd -> correct data is returned.
